// File: rtl/hdmi_tx_sequencer_if.sv
// Bundle between the HDMI transmit sequencer and its environment (clock lock, encoders, gearboxes).
// Latency: none (wires only).
// Backpressure: none; one symbol per channel is exchanged every pixel clock.
interface hdmi_tx_sequencer_if;
    logic        clk_locked;
    logic        enable;
    logic [9:0]  enc_sym0;
    logic [9:0]  enc_sym1;
    logic [9:0]  enc_sym2;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        active;
    logic [9:0]  tx_sym0;
    logic [9:0]  tx_sym1;
    logic [9:0]  tx_sym2;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        running;

    // Environment side: clock generators, encoders and gearboxes.
    modport master (
        output clk_locked, enable, enc_sym0, enc_sym1, enc_sym2,
        input  h_count, v_count, active, tx_sym0, tx_sym1, tx_sym2,
        input  de, hsync, vsync, frame_start, running
    );

    // Sequencer side.
    modport slave (
        input  clk_locked, enable, enc_sym0, enc_sym1, enc_sym2,
        output h_count, v_count, active, tx_sym0, tx_sym1, tx_sym2,
        output de, hsync, vsync, frame_start, running
    );
endinterface

// File: rtl/hdmi_tx_sequencer.sv
// HDMI/DVI transmit sequencer: lock wait, raster counters, per-channel data/control-token select.
// Latency: TX symbols, DE, syncs and FRAME_START registered 1 cycle after the H/V/ACTIVE that produced them.
// Backpressure: none; the gearboxes take one symbol per channel every pixel clock.
module hdmi_tx_sequencer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOCK_WAIT = 1024
) (
    input  logic                 clock_px,
    input  logic                 reset_n,
    hdmi_tx_sequencer_if.slave   bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);

    // DVI control tokens indexed by {c1, c0}.
    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || LOCK_WAIT < 2) begin : g_param_check
            $error("hdmi_tx_sequencer: raster totals must be <= 4096 and LOCK_WAIT >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_STOPPING
    } state_t;

    function automatic logic [9:0] ctl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = TOK_00;
            2'b01:   tok = TOK_01;
            2'b10:   tok = TOK_10;
            default: tok = TOK_11;
        endcase
        return tok;
    endfunction

    state_t        state, state_nx;
    logic [11:0]   h, h_nx, h_inc;
    logic [11:0]   v, v_nx, v_inc;
    logic [CW-1:0] cnt, cnt_nx;
    logic          lock_meta, lock_s;
    logic          streaming, active, hs, vs, hs_lvl, vs_lvl;
    logic          h_last, v_last;

    logic [9:0]    tx_sym0_q, tx_sym1_q, tx_sym2_q;
    logic          de_q, hsync_q, vsync_q, frame_start_q;

    // Bring the asynchronous lock indication into the pixel-clock domain.
    always_ff @(posedge clock_px or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.clk_locked;
            lock_s    <= lock_meta;
        end
    end

    // State, raster counters and lock-wait counter.
    always_ff @(posedge clock_px or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            h     <= '0;
            v     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            h     <= h_nx;
            v     <= v_nx;
            cnt   <= cnt_nx;
        end
    end

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);
    assign h_inc  = h_last ? 12'd0 : h + 12'd1;
    assign v_inc  = h_last ? (v_last ? 12'd0 : v + 12'd1) : v;

    // Next state; the IDLE cycle that first sees lock counts as the first lock-wait cycle.
    always_comb begin
        state_nx = state;
        h_nx     = h;
        v_nx     = v;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                h_nx   = '0;
                v_nx   = '0;
                cnt_nx = '0;
                if (lock_s && bus.enable) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                h_nx = '0;
                v_nx = '0;
                if (!lock_s || !bus.enable) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nx = ST_IDLE;
                    h_nx     = '0;
                    v_nx     = '0;
                end else begin
                    h_nx = h_inc;
                    v_nx = v_inc;
                    if (!bus.enable) state_nx = ST_STOPPING;
                end
            end
            default: begin
                if (!lock_s) begin
                    state_nx = ST_IDLE;
                    h_nx     = '0;
                    v_nx     = '0;
                end else begin
                    h_nx = h_inc;
                    v_nx = v_inc;
                    if (bus.enable)              state_nx = ST_RUN;
                    else if (h_last && v_last)   state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // Region decode; sync pulses only exist while streaming.
    always_comb begin
        streaming = (state == ST_RUN) || (state == ST_STOPPING);
        active    = streaming && ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
        hs        = streaming && ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
        vs        = streaming && ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
        hs_lvl    = hs ? HS_POL : ~HS_POL;
        vs_lvl    = vs ? VS_POL : ~VS_POL;
    end

    // Output stage: one symbol per channel per pixel, registered for the gearboxes.
    always_ff @(posedge clock_px or negedge reset_n) begin
        if (!reset_n) begin
            tx_sym0_q     <= ctl_token(~VS_POL, ~HS_POL);
            tx_sym1_q     <= TOK_00;
            tx_sym2_q     <= TOK_00;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            tx_sym0_q     <= active ? bus.enc_sym0 : ctl_token(vs_lvl, hs_lvl);
            tx_sym1_q     <= active ? bus.enc_sym1 : TOK_00;
            tx_sym2_q     <= active ? bus.enc_sym2 : TOK_00;
            de_q          <= active;
            hsync_q       <= hs_lvl;
            vsync_q       <= vs_lvl;
            frame_start_q <= streaming && (h == 12'd0) && (v == 12'd0);
        end
    end

    assign bus.h_count     = h;
    assign bus.v_count     = v;
    assign bus.active      = active;
    assign bus.running     = streaming;
    assign bus.tx_sym0     = tx_sym0_q;
    assign bus.tx_sym1     = tx_sym1_q;
    assign bus.tx_sym2     = tx_sym2_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_hdmi_tx_sequencer.sv
// Testbench for hdmi_tx_sequencer on an 8x5 raster (H 4/1/2/1, V 2/1/1/1, LOCK_WAIT 4).
// Stimulus pushes expected values tagged with the cycle they apply to; a negedge monitor pops and compares.
// Encoder model presents {tag, H[3:0], V[3:0]} for the pixel the sequencer currently addresses.
module tb_hdmi_tx_sequencer;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hdmi_tx_sequencer_if bus();

    hdmi_tx_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(4)
    ) dut (
        .clock_px (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    assign bus.enc_sym0 = {2'b00, bus.h_count[3:0], bus.v_count[3:0]};
    assign bus.enc_sym1 = {2'b01, bus.h_count[3:0], bus.v_count[3:0]};
    assign bus.enc_sym2 = {2'b10, bus.h_count[3:0], bus.v_count[3:0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {S_TX0, S_TX1, S_TX2, S_DE, S_HS, S_VS, S_FS, S_RUN, S_H, S_V, S_ACT} sig_e;
    typedef struct {
        int          tgt;
        sig_e        sel;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] actual(input sig_e s);
        logic [11:0] r;
        case (s)
            S_TX0:   r = {2'b00, bus.tx_sym0};
            S_TX1:   r = {2'b00, bus.tx_sym1};
            S_TX2:   r = {2'b00, bus.tx_sym2};
            S_DE:    r = {11'd0, bus.de};
            S_HS:    r = {11'd0, bus.hsync};
            S_VS:    r = {11'd0, bus.vsync};
            S_FS:    r = {11'd0, bus.frame_start};
            S_RUN:   r = {11'd0, bus.running};
            S_H:     r = bus.h_count;
            S_V:     r = bus.v_count;
            default: r = {11'd0, bus.active};
        endcase
        return r;
    endfunction

    function automatic string sname(input sig_e s);
        string n;
        case (s)
            S_TX0:   n = "tx_sym0";
            S_TX1:   n = "tx_sym1";
            S_TX2:   n = "tx_sym2";
            S_DE:    n = "de";
            S_HS:    n = "hsync";
            S_VS:    n = "vsync";
            S_FS:    n = "frame_start";
            S_RUN:   n = "running";
            S_H:     n = "h_count";
            S_V:     n = "v_count";
            default: n = "active";
        endcase
        return n;
    endfunction

    function automatic logic [9:0] tok(input bit c1, input bit c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b00:   t = TOK00;
            2'b01:   t = TOK01;
            2'b10:   t = TOK10;
            default: t = TOK11;
        endcase
        return t;
    endfunction

    // Monitor: compare every expectation whose target cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.tgt < cyc || actual(e.sel) !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d): got %h expected %h",
                         sname(e.sel), cyc, e.tgt, actual(e.sel), e.val);
            end
        end
    end

    task automatic chk(input sig_e s, input logic [11:0] v, input int dly);
        exp_t e;
        e.tgt = cyc + dly;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset-equivalent registered outputs, due dly cycles from now.
    task automatic idle_out(input int dly);
        chk(S_DE,  12'd0, dly);
        chk(S_HS,  12'd1, dly);
        chk(S_VS,  12'd1, dly);
        chk(S_FS,  12'd0, dly);
        chk(S_TX0, {2'b00, TOK11}, dly);
        chk(S_TX1, {2'b00, TOK00}, dly);
        chk(S_TX2, {2'b00, TOK00}, dly);
    endtask

    task automatic idle_int();
        chk(S_RUN, 12'd0, 0);
        chk(S_H,   12'd0, 0);
        chk(S_V,   12'd0, 0);
        chk(S_ACT, 12'd0, 0);
    endtask

    // Streaming pixel (h,v): counters now, registered outputs next cycle.
    task automatic exp_pixel(input int h, input int v);
        bit de_e, hl, vl;
        de_e = (h < 4) && (v < 2);
        hl   = !(h == 5 || h == 6);
        vl   = (v != 3);
        chk(S_H,   12'(h), 0);
        chk(S_V,   12'(v), 0);
        chk(S_ACT, {11'd0, de_e}, 0);
        chk(S_RUN, 12'd1, 0);
        chk(S_DE,  {11'd0, de_e}, 1);
        chk(S_HS,  {11'd0, hl}, 1);
        chk(S_VS,  {11'd0, vl}, 1);
        chk(S_FS,  {11'd0, (h == 0 && v == 0)}, 1);
        chk(S_TX0, {2'b00, (de_e ? {2'b00, 4'(h), 4'(v)} : tok(vl, hl))}, 1);
        chk(S_TX1, {2'b00, (de_e ? {2'b01, 4'(h), 4'(v)} : TOK00)}, 1);
        chk(S_TX2, {2'b00, (de_e ? {2'b10, 4'(h), 4'(v)} : TOK00)}, 1);
    endtask

    // npix pixels from (0,0); enable toggled at the given pixel indices (-1 = never).
    task automatic frame(input int npix, input int off_idx, input int on_idx);
        for (int i = 0; i < npix; i++) begin
            exp_pixel(i % 8, i / 8);
            if (i == off_idx) bus.enable = 1'b0;
            if (i == on_idx)  bus.enable = 1'b1;
            step();
        end
    endtask

    // Lock just raised from IDLE with lock_s low: 2 sync + 4 wait cycles before RUN.
    task automatic lock_to_run();
        for (int i = 1; i <= 5; i++) begin
            step();
            chk(S_RUN, 12'd0, 0);
            idle_out(0);
        end
        step();
        idle_out(0);
    endtask

    initial begin
        bus.clk_locked = 1'b0;
        bus.enable     = 1'b0;
        rst_n          = 1'b0;
        step();
        step();
        idle_int();
        idle_out(0);
        step();
        rst_n = 1'b1;
        step();
        step();
        idle_int();
        idle_out(0);

        // Lock and enable: RUN after 6 cycles, then a full frame and a stopping frame.
        bus.clk_locked = 1'b1;
        bus.enable     = 1'b1;
        lock_to_run();
        frame(40, -1, -1);
        frame(40, 1 * 8 + 2, -1);
        idle_int();
        idle_out(1);
        step();
        step();
        step();
        idle_int();
        idle_out(0);

        // Restart with lock already synchronized: the IDLE cycle counts toward the wait.
        bus.enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk(S_RUN, 12'd0, 0);
        end
        step();
        frame(40, 1 * 8 + 2, 1 * 8 + 5);
        frame(40, -1, -1);

        // Lock lost mid-line at H=2: two sync cycles, then abort.
        frame(2, -1, -1);
        exp_pixel(2, 0);
        bus.clk_locked = 1'b0;
        step();
        exp_pixel(3, 0);
        step();
        exp_pixel(4, 0);
        step();
        idle_int();
        idle_out(1);
        step();
        step();

        // Re-lock: fresh wait, then a new frame.
        bus.clk_locked = 1'b1;
        lock_to_run();
        frame(16, -1, -1);

        // Drop lock, then glitch it during wait count 3.
        bus.clk_locked = 1'b0;
        repeat (4) step();
        idle_int();
        bus.clk_locked = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 3) bus.clk_locked = 1'b0;
            if (i == 4) bus.clk_locked = 1'b1;
            chk(S_RUN, 12'd0, 0);
            idle_out(0);
        end
        step();
        frame(8, -1, -1);

        // Asynchronous reset in the middle of active video on line 1.
        exp_pixel(0, 1);
        step();
        chk(S_H, 12'd1, 0);
        step();
        idle_int();
        idle_out(0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.de !== 1'b0 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async reset: de=%b frame_start=%b", bus.de, bus.frame_start);
        end
        checks++;
        if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
            errors++;
            $display("FAIL async reset: hsync=%b vsync=%b", bus.hsync, bus.vsync);
        end
        checks++;
        if (bus.tx_sym0 !== TOK11 || bus.tx_sym1 !== TOK00 || bus.tx_sym2 !== TOK00) begin
            errors++;
            $display("FAIL async reset: tx_sym0=%b tx_sym1=%b tx_sym2=%b",
                     bus.tx_sym0, bus.tx_sym1, bus.tx_sym2);
        end
        checks++;
        if (bus.running !== 1'b0 || bus.h_count !== 12'd0 || bus.v_count !== 12'd0) begin
            errors++;
            $display("FAIL async reset: running=%b h=%0d v=%0d",
                     bus.running, bus.h_count, bus.v_count);
        end
        step();
        idle_int();
        idle_out(0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never compared, expected %h", sname(e.sel), e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
